// File: rtl/alu_result_checker.sv
// Response-side checker for the ALU: delays each issued operation by LATENCY
// cycles, compares the delayed expected value against r, and keeps counters/coverage.
module alu_result_checker #(
    parameter int LATENCY     = 1,
    parameter int CNT_W       = 16,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue,
    input  logic [0:7]       a,
    input  logic [0:7]       b,
    input  logic [0:2]       op,
    input  logic [0:7]       r,
    input  logic             clear,
    output logic             err,
    output logic [CNT_W-1:0] chk_count,
    output logic [CNT_W-1:0] err_count,
    output logic [7:0]       op_hit,
    output logic             all_ops_hit,
    output logic             halted,
    output logic [2:0]       fail_op,
    output logic [7:0]       fail_exp,
    output logic [7:0]       fail_got
);

    localparam int LAST = LATENCY - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [7:0] ref_val;
    logic       pipe_v   [LATENCY];
    logic [2:0] pipe_op  [LATENCY];
    logic [7:0] pipe_exp [LATENCY];
    logic       do_cmp;
    logic       mismatch;
    logic       captured;

    // Reference model; bit 0 of the [0:7] vectors is the MSB, so plain arithmetic applies.
    always_comb begin
        ref_val = 8'h00;
        case (op)
            3'd0:    ref_val = a + b;
            3'd1:    ref_val = a - b;
            3'd2:    ref_val = a & b;
            3'd3:    ref_val = a | b;
            3'd4:    ref_val = a ^ b;
            3'd5:    ref_val = ~a;
            3'd6:    ref_val = {a[1:7], 1'b0};
            default: ref_val = {1'b0, a[0:6]};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_v[i]   <= 1'b0;
                pipe_op[i]  <= 3'd0;
                pipe_exp[i] <= 8'h00;
            end
        end else begin
            pipe_v[0]   <= issue;
            pipe_op[0]  <= op;
            pipe_exp[0] <= ref_val;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_op[i]  <= pipe_op[i-1];
                pipe_exp[i] <= pipe_exp[i-1];
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (issue) state_nxt = S_RUN;
            S_RUN:   if (STOP_ON_ERR && mismatch) state_nxt = S_HALT;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
        if (clear) state_nxt = S_IDLE;
    end

    // FSM: outputs; a compare landing on a clear cycle is dropped.
    always_comb begin
        do_cmp   = (state == S_RUN) && pipe_v[LAST] && !clear;
        mismatch = do_cmp && (r != pipe_exp[LAST]);
        halted   = (state == S_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err       <= 1'b0;
            chk_count <= '0;
            err_count <= '0;
            op_hit    <= 8'h00;
            captured  <= 1'b0;
            fail_op   <= 3'd0;
            fail_exp  <= 8'h00;
            fail_got  <= 8'h00;
        end else if (clear) begin
            err       <= 1'b0;
            chk_count <= '0;
            err_count <= '0;
            op_hit    <= 8'h00;
            captured  <= 1'b0;
            fail_op   <= 3'd0;
            fail_exp  <= 8'h00;
            fail_got  <= 8'h00;
        end else begin
            err <= mismatch;
            if (do_cmp) begin
                if (chk_count != '1) chk_count <= chk_count + 1'b1;
                if (mismatch) begin
                    if (err_count != '1) err_count <= err_count + 1'b1;
                    if (!captured) begin
                        captured <= 1'b1;
                        fail_op  <= pipe_op[LAST];
                        fail_exp <= pipe_exp[LAST];
                        fail_got <= r;
                    end
                end else begin
                    op_hit[pipe_op[LAST]] <= 1'b1;
                end
            end
        end
    end

    assign all_ops_hit = (op_hit == 8'hFF);

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker: three instances cover LATENCY=1,
// STOP_ON_ERR=1 with a narrow counter, and LATENCY=3.
module tb_alu_result_checker;

    logic       clk;
    logic       rst_n;
    logic [2:0] issue_v;
    logic [2:0] clear_v;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] r1;
    logic [7:0] r3;

    logic        m_err, m_all, m_halted;
    logic [15:0] m_chk, m_errc;
    logic [7:0]  m_hit, m_fexp, m_fgot;
    logic [2:0]  m_fop;

    logic        s_err, s_all, s_halted;
    logic [3:0]  s_chk, s_errc;
    logic [7:0]  s_hit, s_fexp, s_fgot;
    logic [2:0]  s_fop;

    logic        l_err, l_all, l_halted;
    logic [15:0] l_chk, l_errc;
    logic [7:0]  l_hit, l_fexp, l_fgot;
    logic [2:0]  l_fop;

    int n_checks = 0;
    int n_pass   = 0;

    alu_result_checker #(.LATENCY(1), .CNT_W(16), .STOP_ON_ERR(1'b0)) u_main (
        .clk(clk), .rst_n(rst_n), .issue(issue_v[0]), .a(a), .b(b), .op(op), .r(r1),
        .clear(clear_v[0]), .err(m_err), .chk_count(m_chk), .err_count(m_errc),
        .op_hit(m_hit), .all_ops_hit(m_all), .halted(m_halted), .fail_op(m_fop),
        .fail_exp(m_fexp), .fail_got(m_fgot)
    );

    alu_result_checker #(.LATENCY(1), .CNT_W(4), .STOP_ON_ERR(1'b1)) u_stop (
        .clk(clk), .rst_n(rst_n), .issue(issue_v[1]), .a(a), .b(b), .op(op), .r(r1),
        .clear(clear_v[1]), .err(s_err), .chk_count(s_chk), .err_count(s_errc),
        .op_hit(s_hit), .all_ops_hit(s_all), .halted(s_halted), .fail_op(s_fop),
        .fail_exp(s_fexp), .fail_got(s_fgot)
    );

    alu_result_checker #(.LATENCY(3), .CNT_W(16), .STOP_ON_ERR(1'b0)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .issue(issue_v[2]), .a(a), .b(b), .op(op), .r(r3),
        .clear(clear_v[2]), .err(l_err), .chk_count(l_chk), .err_count(l_errc),
        .op_hit(l_hit), .all_ops_hit(l_all), .halted(l_halted), .fail_op(l_fop),
        .fail_exp(l_fexp), .fail_got(l_fgot)
    );

    // Clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    endtask

    // Drive one cycle of inputs from a negedge through the next negedge.
    task automatic cyc(input logic [2:0] iss, input logic [2:0] clr, input logic [2:0] o,
                       input logic [7:0] aa, input logic [7:0] bb,
                       input logic [7:0] rr1, input logic [7:0] rr3);
        issue_v = iss;
        clear_v = clr;
        op      = o;
        a       = aa;
        b       = bb;
        r1      = rr1;
        r3      = rr3;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(3'b000, 3'b000, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00);
    endtask

    logic [7:0] exp8 [8];
    logic [2:0] l_ops [4];
    logic [7:0] l_a [4];
    logic [7:0] l_b [4];
    logic [7:0] l_exp [4];
    logic [7:0] rv;
    logic       iv;

    initial begin
        exp8 = '{8'h84, 8'h7E, 8'h01, 8'h83, 8'h82, 8'h7E, 8'h02, 8'h40};
        l_ops = '{3'd0, 3'd3, 3'd7, 3'd5};
        l_a   = '{8'h12, 8'hA0, 8'hFF, 8'h3C};
        l_b   = '{8'h34, 8'h05, 8'h00, 8'h00};
        l_exp = '{8'h46, 8'hA5, 8'h7F, 8'hC3};

        rst_n = 1'b0;
        issue_v = 3'b000; clear_v = 3'b000; op = 3'd0;
        a = 8'h00; b = 8'h00; r1 = 8'h00; r3 = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_err", {31'd0, m_err}, 32'd0);
        check("reset_chk", {16'd0, m_chk}, 32'd0);
        check("reset_hit", {24'd0, m_hit}, 32'd0);
        check("reset_halted", {31'd0, s_halted}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single ADD with wrap-around
        cyc(3'b001, 3'b000, 3'd0, 8'hF0, 8'h20, 8'h00, 8'h00);
        cyc(3'b000, 3'b000, 3'd0, 8'h00, 8'h00, 8'h10, 8'h00);
        check("add_err", {31'd0, m_err}, 32'd0);
        check("add_chk", {16'd0, m_chk}, 32'd1);
        check("add_hit", {24'd0, m_hit}, 32'h01);

        // All eight ops back to back after a clear
        cyc(3'b000, 3'b001, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00);
        check("clear_chk", {16'd0, m_chk}, 32'd0);
        for (int i = 0; i <= 8; i++) begin
            iv = (i < 8);
            rv = (i > 0) ? exp8[i-1] : 8'h00;
            cyc({2'b00, iv}, 3'b000, 3'(i), 8'h81, 8'h03, rv, 8'h00);
        end
        check("b2b_chk", {16'd0, m_chk}, 32'd8);
        check("b2b_errc", {16'd0, m_errc}, 32'd0);
        check("b2b_all", {31'd0, m_all}, 32'd1);
        check("b2b_hit", {24'd0, m_hit}, 32'hFF);

        // Bad SUB: 00-01 expects FF, r forced to 00
        cyc(3'b001, 3'b000, 3'd1, 8'h00, 8'h01, 8'h00, 8'h00);
        cyc(3'b000, 3'b000, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00);
        check("sub_err_pulse", {31'd0, m_err}, 32'd1);
        check("sub_errc", {16'd0, m_errc}, 32'd1);
        check("sub_fop", {29'd0, m_fop}, 32'd1);
        check("sub_fexp", {24'd0, m_fexp}, 32'hFF);
        check("sub_fgot", {24'd0, m_fgot}, 32'h00);
        idle(1);
        check("sub_err_low", {31'd0, m_err}, 32'd0);
        // Second bad op (XOR 0F^F0 = FF, r=00) must not disturb the capture
        cyc(3'b001, 3'b000, 3'd4, 8'h0F, 8'hF0, 8'h00, 8'h00);
        cyc(3'b000, 3'b000, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00);
        check("xor_err", {31'd0, m_err}, 32'd1);
        check("xor_errc", {16'd0, m_errc}, 32'd2);
        check("xor_chk", {16'd0, m_chk}, 32'd10);
        check("xor_fop", {29'd0, m_fop}, 32'd1);
        check("xor_fexp", {24'd0, m_fexp}, 32'hFF);
        check("xor_fgot", {24'd0, m_fgot}, 32'h00);

        // Stop-on-error: two good, one bad (OR 10|01 = 11, r=00), then five good issues
        cyc(3'b010, 3'b000, 3'd0, 8'h01, 8'h01, 8'h00, 8'h00);
        cyc(3'b010, 3'b000, 3'd2, 8'hFF, 8'h0F, 8'h02, 8'h00);
        cyc(3'b010, 3'b000, 3'd3, 8'h10, 8'h01, 8'h0F, 8'h00);
        for (int i = 0; i < 5; i++) begin
            rv = (i == 0) ? 8'h00 : 8'h02;
            cyc(3'b010, 3'b000, 3'd0, 8'h01, 8'h01, rv, 8'h00);
        end
        cyc(3'b000, 3'b000, 3'd0, 8'h00, 8'h00, 8'h02, 8'h00);
        check("stop_halted", {31'd0, s_halted}, 32'd1);
        check("stop_chk", {28'd0, s_chk}, 32'd3);
        check("stop_errc", {28'd0, s_errc}, 32'd1);
        check("stop_hit", {24'd0, s_hit}, 32'h05);
        check("stop_fexp", {24'd0, s_fexp}, 32'h11);
        cyc(3'b000, 3'b010, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00);
        check("stop_clr_halted", {31'd0, s_halted}, 32'd0);
        check("stop_clr_chk", {28'd0, s_chk}, 32'd0);
        check("stop_clr_errc", {28'd0, s_errc}, 32'd0);
        check("stop_clr_hit", {24'd0, s_hit}, 32'h00);
        check("stop_clr_fexp", {24'd0, s_fexp}, 32'h00);

        // Saturation of the 4-bit counter: 16 good checks
        for (int i = 0; i <= 16; i++) begin
            iv = (i < 16);
            rv = (i > 0) ? 8'h02 : 8'h00;
            cyc({1'b0, iv, 1'b0}, 3'b000, 3'd0, 8'h01, 8'h01, rv, 8'h00);
            if (i == 15) check("sat_at_max", {28'd0, s_chk}, 32'hF);
        end
        check("sat_hold", {28'd0, s_chk}, 32'hF);
        check("sat_errc", {28'd0, s_errc}, 32'd0);

        // LATENCY=3 with alternating issue/idle; idle r slots carry junk
        for (int i = 0; i < 11; i++) begin
            iv = (i % 2 == 0) && (i < 8);
            rv = (i >= 3 && ((i - 3) % 2 == 0) && ((i - 3) / 2 < 4)) ? l_exp[(i-3)/2] : 8'h00;
            if (iv) cyc(3'b100, 3'b000, l_ops[i/2], l_a[i/2], l_b[i/2], 8'h00, rv);
            else    cyc(3'b000, 3'b000, 3'd0, 8'h00, 8'h00, 8'h00, rv);
            if (i == 3) check("lat3_first", {16'd0, l_chk}, 32'd1);
        end
        check("lat3_chk", {16'd0, l_chk}, 32'd4);
        check("lat3_errc", {16'd0, l_errc}, 32'd0);
        check("lat3_hit", {24'd0, l_hit}, 32'hA9);

        // Reset with two results in flight
        cyc(3'b100, 3'b000, 3'd0, 8'h01, 8'h02, 8'h00, 8'h00);
        cyc(3'b100, 3'b000, 3'd0, 8'h03, 8'h04, 8'h00, 8'h00);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idle(1);
            check("rst_flush_err", {31'd0, l_err}, 32'd0);
        end
        check("rst_flush_chk", {16'd0, l_chk}, 32'd0);
        check("rst_flush_errc", {16'd0, l_errc}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
